iir_pole: RTL and testbench

Recursive (pole) half of the second-order IIR section, placed directly downstream of the numerator (zero) stage. It takes that stage's 24-bit signed sum and computes y[n] = (x[n] − A1·y[n−1] − A2·y[n−2]) >>> SHIFT. One shared multiplier is time-multiplexed under a small FSM. The result is rescaled and saturated back to the 12-bit sample width, and a one-cycle valid strobe is produced per accepted sample.

---
 rtl/iir_pole.sv | 154 +++++++++++++++
 tb/tb_iir_pole.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/iir_pole.sv
// -----------------------------------------------------------------------------
// iir_pole
//
// Recursive (pole) half of a second-order IIR section. It sits directly after
// the numerator (zero) stage and computes
//
//   y[n] = (x[n] - A1*y[n-1] - A2*y[n-2]) >>> SHIFT
//
// using one shared 12x12 multiplier that a four-state FSM time-multiplexes.
// The shifted result is brought back to the 12-bit sample width and is also
// written into the feedback history, so the recursion always uses the value
// that was actually output.
//
// Compile-time option:
//   IIR_POLE_SAT_EN  defined   -> the result is clamped to [-2048, 2047]
//                    undefined -> the result wraps (low 12 bits kept)
//
// Parameters:
//   A1     signed 12-bit feedback coefficient for y[n-1], Q(SHIFT)
//   A2     signed 12-bit feedback coefficient for y[n-2], Q(SHIFT)
//   SHIFT  arithmetic right shift applied to the accumulator (a0 = 2^SHIFT)
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst_n       asynchronous reset, active HIGH (name kept from the codebase)
//   din_valid   din carries a new sample this cycle
//   din         24-bit signed numerator-stage output x[n]
//   dout        12-bit signed filtered sample y[n], held between updates
//   dout_valid  one-cycle pulse when dout updates
//   busy        a sample is in flight; din_valid is ignored while high
//   overrun     sticky: din_valid was seen while busy (cleared by reset only)
//   state_dbg   current FSM state, for debug and assertion binding
//
// Handshake: there is no ready signal. A sample is taken on any rising edge
// where din_valid=1 and busy=0. A din_valid seen while busy=1 drops that
// sample and sets overrun; the computation in flight is not disturbed.
// dout is meaningful on the cycle dout_valid=1 and holds afterwards.
// -----------------------------------------------------------------------------
module iir_pole #(
  parameter logic signed [11:0] A1    = -12'sd1864,
  parameter logic signed [11:0] A2    = 12'sd926,
  parameter int                 SHIFT = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din_valid,
  input  logic signed [23:0] din,
  output logic signed [11:0] dout,
  output logic               dout_valid,
  output logic               busy,
  output logic               overrun,
  output logic [1:0]         state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL1 = 2'd1;
  localparam logic [1:0] MUL2 = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic signed [25:0] acc;
  logic signed [11:0] y1;
  logic signed [11:0] y2;

  // Shared multiplier. Both operands are selected by the registered state
  // only, so din never reaches dout combinationally.
  logic signed [11:0] coef;
  logic signed [11:0] hist;
  logic signed [23:0] prod;
  logic signed [25:0] prod_ext;

  always_comb begin
    coef = A2;
    hist = y2;
    if (state == MUL1) begin
      coef = A1;
      hist = y1;
    end
  end

  // 24-bit operands keep the full 12x12 signed product without truncation.
  assign prod     = 24'(coef) * 24'(hist);
  assign prod_ext = {{2{prod[23]}}, prod};

  // Bring the accumulator back to the 12-bit sample width.
  logic signed [11:0] r12;

`ifdef IIR_POLE_SAT_EN
  logic signed [25:0] r_full;

  assign r_full = acc >>> SHIFT;

  always_comb begin
    r12 = r_full[11:0];
    if (r_full > 26'sd2047) begin
      r12 = 12'sd2047;
    end else if (r_full < -26'sd2048) begin
      r12 = -12'sd2048;
    end
  end
`else
  // Two's-complement wrap: only the low 12 bits of the shifted value survive.
  assign r12 = 12'(acc >>> SHIFT);
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      y1         <= '0;
      y2         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;

      if (din_valid && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (din_valid) begin
            acc   <= {{2{din[23]}}, din};
            state <= MUL1;
          end
        end
        MUL1: begin
          acc   <= acc - prod_ext;
          state <= MUL2;
        end
        MUL2: begin
          acc   <= acc - prod_ext;
          state <= DONE;
        end
        DONE: begin
          dout       <= r12;
          y2         <= y1;
          y1         <= r12;
          dout_valid <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_iir_pole.sv
// -----------------------------------------------------------------------------
// tb_iir_pole
//
// Directed bench for iir_pole with default parameters (A1=-1864, A2=926,
// SHIFT=10). Expected outputs are hand-computed from
//   y[n] = floor((x[n] + 1864*y[n-1] - 926*y[n-2]) / 1024)
// Inputs change 1 time unit after a rising edge; outputs are read at the
// same point, i.e. after the edge has settled.
// -----------------------------------------------------------------------------
module tb_iir_pole;

  logic               clk;
  logic               rst_n;
  logic               din_valid;
  logic signed [23:0] din;
  logic signed [11:0] dout;
  logic               dout_valid;
  logic               busy;
  logic               overrun;
  logic [1:0]         state_dbg;

  int vectors;
  int miscompares;
  int pulse_cnt;

  iir_pole dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .overrun    (overrun),
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts dout_valid pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (dout_valid === 1'b1) pulse_cnt++;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    din_valid = 1'b0;
    din       = '0;
    rst_n     = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
  endtask

  // One sample: accept at edge k, result expected right after edge k+3.
  // Returns right after k+3 so the next call is accepted at k+4.
  task automatic run_sample(input string tag, input logic signed [23:0] x,
                            input logic signed [31:0] exp);
    din_valid = 1'b1;
    din       = x;
    tick();
    din_valid = 1'b0;
    check({tag, "_busy_k"}, busy, 1);
    check({tag, "_dv_low_k"}, dout_valid, 0);
    tick();
    tick();
    check({tag, "_busy_k2"}, busy, 1);
    check({tag, "_dv_low_k2"}, dout_valid, 0);
    tick();
    check({tag, "_dv"}, dout_valid, 1);
    check({tag, "_dout"}, dout, exp);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pulse_cnt   = 0;
    rst_n       = 1'b1;
    din_valid   = 1'b0;
    din         = '0;

    // Reset state
    apply_reset();
    check("rst_dout", dout, 0);
    check("rst_dv", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", state_dbg, 0);

    // Impulse response: 100, 182, 240 at 4-clock spacing
    pulse_cnt = 0;
    run_sample("imp0", 24'sd102400, 100);
    run_sample("imp1", 24'sd0, 182);
    run_sample("imp2", 24'sd0, 240);
    tick();
    check("imp_dv_drop", dout_valid, 0);
    check("imp_pulses", pulse_cnt, 3);
    check("imp_hold", dout, 240);
    check("imp_no_overrun", overrun, 0);

    // Saturation / wrap with zero history
    apply_reset();
`ifdef IIR_POLE_SAT_EN
    run_sample("sat_pos", 24'sd8388607, 2047);
`else
    run_sample("sat_pos", 24'sd8388607, -1);
`endif
    apply_reset();
`ifdef IIR_POLE_SAT_EN
    run_sample("sat_neg", -24'sd8388608, -2048);
`else
    run_sample("sat_neg", -24'sd8388608, 0);
`endif

    // Floor rounding toward -inf
    apply_reset();
    run_sample("floor_neg", -24'sd1, -1);
    apply_reset();
    run_sample("floor_pos", 24'sd1023, 0);

    // Overrun: din_valid held for 12 clocks -> accepts at edges 1, 5, 9
    apply_reset();
    pulse_cnt = 0;
    din_valid = 1'b1;
    din       = 24'sd102400;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) check("ovr_not_yet", overrun, 0);
      if (i == 2) check("ovr_set", overrun, 1);
      if (i == 4) check("ovr_out0", dout, 100);
      if (i == 8) check("ovr_out1", dout, 282);
      if (i == 12) check("ovr_out2", dout, 522);
    end
    din_valid = 1'b0;
    tick();
    tick();
    tick();
    check("ovr_pulses", pulse_cnt, 3);
    check("ovr_sticky", overrun, 1);
    check("ovr_idle", busy, 0);

    // Reset in MUL2 with nonzero history (y1=522, y2=282)
    din_valid = 1'b1;
    din       = 24'sd0;
    tick();
    din_valid = 1'b0;
    tick();
    check("mid_in_mul2", state_dbg, 2);
    pulse_cnt = 0;
    #1;
    rst_n = 1'b1;
    #1;
    check("mid_busy", busy, 0);
    check("mid_dout", dout, 0);
    check("mid_overrun", overrun, 0);
    check("mid_state", state_dbg, 0);
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    tick();
    check("mid_no_pulse", pulse_cnt, 0);
    run_sample("mid_after", 24'sd102400, 100);

    // Summary
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
